// File: rtl/keyboard_tx.sv
// keyboard_tx -- Amiga-style keyboard serial transmitter.
//
// Shifts 8-bit key codes to the host CIA over an open-drain KB_CLOCK/KB_DATA
// pair, waits for the CIA's low-pulse handshake on KB_DATA, and recovers
// from lost synchronisation by clocking single 1 bits until a handshake
// arrives. It then sends the lost-sync code 0xF9 and retransmits the failed
// byte. After reset it sends 0xFD then 0xFE before accepting keys.
//
// Ports:
//   CLKCPU_A   in   sole clock, rising edge
//   RESET_N    in   asynchronous active-low reset
//   KEY_CODE   in   [7] up(1)/down(0), [6:0] raw keycode
//   KEY_VALID  in   KEY_CODE is offered
//   KEY_READY  out  a code is accepted this cycle if KEY_VALID is high
//   KB_CLOCK   out  open-drain keyboard clock (0 or high-Z)
//   KB_DATA    io   open-drain keyboard data (0 or high-Z), read back for handshake
//   SYNC_LOST  out  one-clock pulse on every handshake timeout
//
// Handshake on the key input: a code transfers on a rising edge where
// KEY_VALID and KEY_READY are both 1; KEY_READY is high only in IDLE, so it
// drops on the cycle after the transfer.
module keyboard_tx #(
  parameter int T_BIT        = 568,
  parameter int T_HS_MIN     = 29,
  parameter int T_HS_TIMEOUT = 4056000
) (
  input  logic       CLKCPU_A,
  input  logic       RESET_N,
  input  logic [7:0] KEY_CODE,
  input  logic       KEY_VALID,
  output logic       KEY_READY,
  output wire        KB_CLOCK,
  inout  wire        KB_DATA,
  output logic       SYNC_LOST
);

  localparam int CNT_W = $clog2(T_HS_TIMEOUT + 1);
  localparam int HS_W  = $clog2(T_HS_MIN + 1);

  typedef enum logic [2:0] {
    PWRUP, IDLE, SETUP, CLK_LOW, CLK_HIGH, HS_WAIT, HS_RELEASE, RESYNC
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;        // clocks spent in the current state
  logic [HS_W-1:0]  hs_cnt_q, hs_cnt_d;  // consecutive synchronized-low clocks
  logic [7:0]       shift_q, shift_d;    // byte on the wire, MSB goes next
  logic [2:0]       bit_cnt_q, bit_cnt_d;// bits remaining after the current one
  logic [7:0]       cur_q, cur_d;        // byte to retransmit after a resync
  logic [1:0]       pwr_q, pwr_d;        // 0: sending FD, 1: sending FE, 2: done
  logic             resync_q, resync_d;  // current transfer is the single resync bit
  logic             f9_q, f9_d;          // current transfer is the lost-sync code
  logic             sync1_q, sync2_q;
  logic             phase_done;
  logic             data_low;
  logic             key_ready;
  logic             sync_lost;

  always_ff @(posedge CLKCPU_A or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= PWRUP;
      cnt_q     <= '0;
      hs_cnt_q  <= '0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      cur_q     <= '0;
      pwr_q     <= '0;
      resync_q  <= 1'b0;
      f9_q      <= 1'b0;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hs_cnt_q  <= hs_cnt_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      cur_q     <= cur_d;
      pwr_q     <= pwr_d;
      resync_q  <= resync_d;
      f9_q      <= f9_d;
      sync1_q   <= KB_DATA;
      sync2_q   <= sync1_q;
    end
  end

  assign phase_done = (cnt_q == CNT_W'(T_BIT - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    hs_cnt_d  = hs_cnt_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    cur_d     = cur_q;
    pwr_d     = pwr_q;
    resync_d  = resync_q;
    f9_d      = f9_q;
    key_ready = 1'b0;
    sync_lost = 1'b0;

    case (state_q)
      PWRUP: begin
        shift_d   = 8'hFD;
        cur_d     = 8'hFD;
        bit_cnt_d = 3'd7;
        state_d   = SETUP;
      end
      IDLE: begin
        key_ready = 1'b1;
        if (KEY_VALID) begin
          // Up/down flag travels last: {code[6:0], code[7]}.
          shift_d   = {KEY_CODE[6:0], KEY_CODE[7]};
          cur_d     = {KEY_CODE[6:0], KEY_CODE[7]};
          bit_cnt_d = 3'd7;
          state_d   = SETUP;
        end
      end
      // RESYNC doubles as the setup phase of the single resync bit.
      SETUP, RESYNC: begin
        if (phase_done) state_d = CLK_LOW;
      end
      CLK_LOW: begin
        if (phase_done) state_d = CLK_HIGH;
      end
      CLK_HIGH: begin
        if (phase_done) begin
          if (bit_cnt_q == 3'd0) begin
            state_d = HS_WAIT;
          end else begin
            shift_d   = shift_q << 1;
            bit_cnt_d = bit_cnt_q - 3'd1;
            state_d   = SETUP;
          end
        end
      end
      HS_WAIT: begin
        if (!sync2_q && (int'(hs_cnt_q) + 1 >= T_HS_MIN)) begin
          state_d = HS_RELEASE;
        end else begin
          hs_cnt_d = sync2_q ? '0 : hs_cnt_q + 1'b1;
          if (cnt_q == CNT_W'(T_HS_TIMEOUT - 1)) begin
            // cur_q is left untouched so the failed byte survives the resync.
            sync_lost = 1'b1;
            shift_d   = 8'h80;
            bit_cnt_d = 3'd0;
            resync_d  = 1'b1;
            f9_d      = 1'b0;
            state_d   = RESYNC;
          end
        end
      end
      HS_RELEASE: begin
        if (sync2_q) begin
          bit_cnt_d = 3'd7;
          if (resync_q) begin
            resync_d = 1'b0;
            f9_d     = 1'b1;
            shift_d  = 8'hF9;
            state_d  = SETUP;
          end else if (f9_q) begin
            f9_d    = 1'b0;
            shift_d = cur_q;
            state_d = SETUP;
          end else if (pwr_q == 2'd0) begin
            pwr_d   = 2'd1;
            shift_d = 8'hFE;
            cur_d   = 8'hFE;
            state_d = SETUP;
          end else begin
            pwr_d   = 2'd2;
            state_d = IDLE;
          end
        end
      end
      default: state_d = PWRUP;
    endcase

    if (state_d != state_q) begin
      cnt_d    = '0;
      hs_cnt_d = '0;
    end
  end

  // A 1 bit is sent as a driven low; a 0 bit leaves the line released.
  assign data_low  = ((state_q == SETUP) || (state_q == CLK_LOW) ||
                      (state_q == CLK_HIGH) || (state_q == RESYNC)) && shift_q[7];
  assign KB_DATA   = data_low ? 1'b0 : 1'bz;
  assign KB_CLOCK  = (state_q == CLK_LOW) ? 1'b0 : 1'bz;
  assign KEY_READY = key_ready;
  assign SYNC_LOST = sync_lost;

endmodule
